// File: rtl/video_tim_pkg.sv
// Shared widths, reset constants and the window comparator used by both
// timing axes of the video timing generator.
package video_tim_pkg;

    localparam int HW_DEF = 16;
    localparam int VW_DEF = 16;
    localparam int SW_DEF = 8;

    // Window compares are done at a generous fixed width so that
    // start/end sums never wrap back into the visible range.
    localparam int PH_W = 32;

    localparam logic RST_GATE  = 1'b0;
    localparam logic RST_PULSE = 1'b0;

    function automatic logic in_phase(input logic [PH_W-1:0] pos,
                                      input logic [PH_W-1:0] lo,
                                      input logic [PH_W-1:0] hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/video_tim_axis.sv
// One timing axis: position counter plus sync, gate and terminal compares.
// Used for the horizontal axis (advanced per pixel) and the vertical axis
// (advanced once per line).
module video_tim_axis
    import video_tim_pkg::*;
#(
    parameter int W  = HW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    input  logic [W-1:0]  len,
    input  logic [SW-1:0] sync_w,
    input  logic [SW-1:0] gdel,
    input  logic [W-1:0]  gate_w,
    output logic [W-1:0]  pos,
    output logic          sync_act,
    output logic          gate_act,
    output logic          done
);

    localparam int CW = W + 1;

    logic [CW-1:0] gate_lo;
    logic [CW-1:0] gate_hi;

    // Gate window bounds and compares; the window is clipped naturally
    // because pos never exceeds len.
    always_comb begin
        gate_lo  = CW'(sync_w) + CW'(gdel) + CW'(2);
        gate_hi  = gate_lo + CW'(gate_w);
        sync_act = PH_W'(pos) <= PH_W'(sync_w);
        gate_act = in_phase(PH_W'(pos), PH_W'(gate_lo), PH_W'(gate_hi));
        done     = (pos == len);
    end

    // Position counter: wraps to zero after len, held at zero while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (adv) begin
            pos <= done ? '0 : pos + W'(1);
        end
    end

endmodule

// File: rtl/video_timgen_ext.sv
// Horizontal/vertical video timing generator with frame-synchronous
// shadow registers, programmable sync polarity and registered outputs.
module video_timgen_ext
    import video_tim_pkg::*;
#(
    parameter int HW = HW_DEF,
    parameter int VW = VW_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_ena,
    input  logic          run,
    input  logic [SW-1:0] Thsync,
    input  logic [SW-1:0] Thgdel,
    input  logic [HW-1:0] Thgate,
    input  logic [HW-1:0] Thlen,
    input  logic [SW-1:0] Tvsync,
    input  logic [SW-1:0] Tvgdel,
    input  logic [VW-1:0] Tvgate,
    input  logic [VW-1:0] Tvlen,
    input  logic [VW-1:0] Tvmatch,
    input  logic          hpol,
    input  logic          vpol,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          gate,
    output logic          blank,
    output logic          eol,
    output logic          eof,
    output logic          vmatch
);

    logic [SW-1:0] sh_hsync, sh_hgdel, sh_vsync, sh_vgdel;
    logic [HW-1:0] sh_hgate, sh_hlen;
    logic [VW-1:0] sh_vgate, sh_vlen, sh_vmatch;
    logic          sh_hpol, sh_vpol;

    logic [HW-1:0] h_pos;
    logic [VW-1:0] v_pos;
    logic          h_sync, h_gate, h_done;
    logic          v_sync, v_gate, v_done;
    logic          eof_c, vmatch_c, shadow_load;

    logic          hs_act_q, vs_act_q, hpol_q, vpol_q, live_q;

    // Shadows follow the live fields while idle, and are committed at the
    // last pixel of a frame so the next frame starts on the new timing.
    assign eof_c       = h_done & v_done;
    assign vmatch_c    = (h_pos == '0) & (v_pos == sh_vmatch);
    assign shadow_load = ~run | (clk_ena & eof_c);

    // Shadow timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hsync  <= '0;
            sh_hgdel  <= '0;
            sh_hgate  <= '0;
            sh_hlen   <= '0;
            sh_vsync  <= '0;
            sh_vgdel  <= '0;
            sh_vgate  <= '0;
            sh_vlen   <= '0;
            sh_vmatch <= '0;
            sh_hpol   <= 1'b0;
            sh_vpol   <= 1'b0;
        end else if (shadow_load) begin
            sh_hsync  <= Thsync;
            sh_hgdel  <= Thgdel;
            sh_hgate  <= Thgate;
            sh_hlen   <= Thlen;
            sh_vsync  <= Tvsync;
            sh_vgdel  <= Tvgdel;
            sh_vgate  <= Tvgate;
            sh_vlen   <= Tvlen;
            sh_vmatch <= Tvmatch;
            sh_hpol   <= hpol;
            sh_vpol   <= vpol;
        end
    end

    video_tim_axis #(.W(HW), .SW(SW)) u_haxis (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~run),
        .adv      (clk_ena),
        .len      (sh_hlen),
        .sync_w   (sh_hsync),
        .gdel     (sh_hgdel),
        .gate_w   (sh_hgate),
        .pos      (h_pos),
        .sync_act (h_sync),
        .gate_act (h_gate),
        .done     (h_done)
    );

    video_tim_axis #(.W(VW), .SW(SW)) u_vaxis (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (~run),
        .adv      (clk_ena & h_done),
        .len      (sh_vlen),
        .sync_w   (sh_vsync),
        .gdel     (sh_vgdel),
        .gate_w   (sh_vgate),
        .pos      (v_pos),
        .sync_act (v_sync),
        .gate_act (v_gate),
        .done     (v_done)
    );

    // Output stage: captures position and compare results together so every
    // output lines up with the hpos/vpos it is presented with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos     <= '0;
            vpos     <= '0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            gate     <= RST_GATE;
            eol      <= RST_PULSE;
            eof      <= RST_PULSE;
            vmatch   <= RST_PULSE;
            hpol_q   <= 1'b0;
            vpol_q   <= 1'b0;
            live_q   <= 1'b0;
        end else if (!run) begin
            hpos     <= '0;
            vpos     <= '0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            gate     <= RST_GATE;
            eol      <= RST_PULSE;
            eof      <= RST_PULSE;
            vmatch   <= RST_PULSE;
            hpol_q   <= 1'b0;
            vpol_q   <= 1'b0;
            live_q   <= 1'b0;
        end else if (clk_ena) begin
            hpos     <= h_pos;
            vpos     <= v_pos;
            hs_act_q <= h_sync;
            vs_act_q <= v_sync;
            gate     <= h_gate & v_gate;
            eol      <= h_done;
            eof      <= eof_c;
            vmatch   <= vmatch_c;
            hpol_q   <= sh_hpol;
            vpol_q   <= sh_vpol;
            live_q   <= 1'b1;
        end
    end

    // While idle the syncs sit at the inactive level of the live polarity
    // inputs; once running they use the polarity of the frame being shown.
    always_comb begin
        hsync = live_q ? ~(hs_act_q ^ hpol_q) : ~hpol;
        vsync = live_q ? ~(vs_act_q ^ vpol_q) : ~vpol;
        blank = ~gate;
    end

endmodule

// File: tb/tb_video_timgen_ext.sv
// Directed bench for the video timing generator.
module tb_video_timgen_ext;

    logic        clk = 1'b0;
    logic        rst_n, clk_ena, run;
    logic [7:0]  Thsync, Thgdel, Tvsync, Tvgdel;
    logic [15:0] Thgate, Thlen, Tvgate, Tvlen, Tvmatch;
    logic        hpol, vpol;
    logic [15:0] hpos, vpos;
    logic        hsync, vsync, gate, blank, eol, eof, vmatch;

    int total = 0;
    int bad   = 0;
    int n_eol;

    always #5 clk = ~clk;

    video_timgen_ext dut (
        .clk(clk), .rst_n(rst_n), .clk_ena(clk_ena), .run(run),
        .Thsync(Thsync), .Thgdel(Thgdel), .Thgate(Thgate), .Thlen(Thlen),
        .Tvsync(Tvsync), .Tvgdel(Tvgdel), .Tvgate(Tvgate), .Tvlen(Tvlen),
        .Tvmatch(Tvmatch), .hpol(hpol), .vpol(vpol),
        .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
        .gate(gate), .blank(blank), .eol(eol), .eof(eof), .vmatch(vmatch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs at position (h,v): hsync high (hpol=1) for h 0..1,
    // hgate from 4 to 4+thgate clipped at thlen, vsync low (vpol=0) on
    // line 0, vgate on lines 2..3, last line 4, vmatch on line 2.
    task automatic chk_pos(input int h, input int v, input int thlen, input int thgate);
        string at;
        at = $sformatf("@%0d,%0d", h, v);
        chk({"hpos", at}, 32'(hpos), 32'(h));
        chk({"vpos", at}, 32'(vpos), 32'(v));
        chk({"hsync", at}, 32'(hsync), 32'(h <= 1));
        chk({"vsync", at}, 32'(vsync), 32'(v != 0));
        chk({"gate", at}, 32'(gate),
            32'((h >= 4) && (h <= 4 + thgate) && (h <= thlen) && (v >= 2) && (v <= 3)));
        chk({"blank", at}, 32'(blank), 32'(!((h >= 4) && (h <= 4 + thgate) && (v >= 2) && (v <= 3))));
        chk({"eol", at}, 32'(eol), 32'(h == thlen));
        chk({"eof", at}, 32'(eof), 32'((h == thlen) && (v == 4)));
        chk({"vmatch", at}, 32'(vmatch), 32'((h == 0) && (v == 2)));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_hpos"}, 32'(hpos), 32'd0);
        chk({tag, "_vpos"}, 32'(vpos), 32'd0);
        chk({tag, "_hsync"}, 32'(hsync), 32'd0);
        chk({tag, "_vsync"}, 32'(vsync), 32'd1);
        chk({tag, "_gate"}, 32'(gate), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd1);
        chk({tag, "_eol"}, 32'(eol), 32'd0);
        chk({tag, "_eof"}, 32'(eof), 32'd0);
        chk({tag, "_vmatch"}, 32'(vmatch), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; clk_ena = 1'b0;
        Thsync = 8'd1; Thgdel = 8'd1; Thgate = 16'd3; Thlen = 16'd9;
        Tvsync = 8'd0; Tvgdel = 8'd0; Tvgate = 16'd1; Tvlen = 16'd4; Tvmatch = 16'd2;
        hpol = 1'b1; vpol = 1'b0;
        #3;
        chk_idle("reset");

        #10 rst_n = 1'b1;
        step();
        step();
        chk_idle("idle0");

        // frames 1 and 2: 10 pixels x 5 lines; Thlen raised mid-frame 2
        run = 1'b1; clk_ena = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk_pos(i % 10, i / 10, 9, 3);
        end
        for (int i = 0; i < 50; i++) begin
            step();
            chk_pos(i % 10, i / 10, 9, 3);
            if (i == 10) Thlen = 16'd19;
        end

        // frame 3: new line length in effect
        for (int i = 0; i < 100; i++) begin
            step();
            chk_pos(i % 20, i / 20, 19, 3);
        end

        // frame 4: pixel enable toggling, outputs frozen on disabled cycles
        n_eol = 0;
        for (int k = 0; k < 30; k++) begin
            clk_ena = 1'b1;
            step();
            chk_pos(k % 20, k / 20, 19, 3);
            if (eol) n_eol++;
            clk_ena = 1'b0;
            step();
            chk_pos(k % 20, k / 20, 19, 3);
        end
        chk("eol_enabled_count", 32'(n_eol), 32'd1);
        clk_ena = 1'b1;
        for (int k = 30; k < 100; k++) begin
            step();
            chk_pos(k % 20, k / 20, 19, 3);
        end

        // run low: idle on the next clock
        run = 1'b0;
        step();
        chk_idle("stop");
        Thlen = 16'd9; Thgate = 16'd15;
        step();
        chk_idle("stop2");

        // frame 5: gate window wider than the line gets clipped at wrap
        run = 1'b1;
        for (int i = 0; i < 35; i++) begin
            step();
            chk_pos(i % 10, i / 10, 9, 15);
        end

        // asynchronous reset in the middle of an active gate
        #2 rst_n = 1'b0;
        #1;
        chk_idle("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
